// File: rtl/sp_icache_ctrl_slave_fsm.sv
//------------------------------------------------------------------------------
// Module      : sp_icache_ctrl_slave_fsm
// Description : Cache-side responder for the single-port icache control
//               channel. Runs the enable / disable / flush 4-phase
//               request/acknowledge handshakes against the cache datapath,
//               drains outstanding refills before acknowledging, and keeps
//               the pending-transaction flag and the saturating hit,
//               transaction and miss performance counters.
// Ports       : clk_i, rst_i (sync, active-high)
//               ctrl_req_{enable,disable}_i, flush_req_i  -> level requests
//               ctrl_ack_{enable,disable}_o, flush_ack_o  -> acknowledges
//               icache_is_private_i -> mode latched into cache_private_o
//               ctrl_clear_regs_i / ctrl_enable_regs_i -> perf counter control
//               ctrl_{hit,trans,miss}_count_o -> 32-bit saturating counters
//               ctrl_pending_trans_o -> refills outstanding (registered)
//               cache_enable_o / cache_private_o / cache_flush_o -> datapath
//               cache_flush_done_i -> invalidate-all complete pulse
//               fetch_{valid,hit,miss}_i -> perf events
//               refill_issue_i / refill_done_i / refill_stall_o -> refills
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sp_icache_ctrl_slave_fsm #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_req_enable_i,
  input  logic        ctrl_req_disable_i,
  input  logic        flush_req_i,
  input  logic        icache_is_private_i,
  input  logic        ctrl_clear_regs_i,
  input  logic        ctrl_enable_regs_i,
  output logic        ctrl_ack_enable_o,
  output logic        ctrl_ack_disable_o,
  output logic        flush_ack_o,
  output logic        ctrl_pending_trans_o,
  output logic [31:0] ctrl_hit_count_o,
  output logic [31:0] ctrl_trans_count_o,
  output logic [31:0] ctrl_miss_count_o,
  output logic        cache_enable_o,
  output logic        cache_private_o,
  output logic        cache_flush_o,
  input  logic        cache_flush_done_i,
  input  logic        fetch_valid_i,
  input  logic        fetch_hit_i,
  input  logic        fetch_miss_i,
  input  logic        refill_issue_i,
  input  logic        refill_done_i,
  output logic        refill_stall_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUTSTANDING);

  localparam logic [2:0] ST_DISABLED  = 3'd0;
  localparam logic [2:0] ST_ENABLED   = 3'd1;
  localparam logic [2:0] ST_DIS_DRAIN = 3'd2;
  localparam logic [2:0] ST_FL_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FL_WAIT   = 3'd4;
  localparam logic [2:0] ST_ACK       = 3'd5;

  // Which handshake the ACK state is currently answering.
  localparam logic [1:0] OP_ENABLE  = 2'd0;
  localparam logic [1:0] OP_DISABLE = 2'd1;
  localparam logic [1:0] OP_FLUSH   = 2'd2;

  logic [2:0]    state;
  logic [1:0]    op;
  logic          op_req;
  logic          cache_en;
  logic          cache_priv;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic          issue_ok;
  logic          done_ok;
  logic          pending;
  logic [31:0]   hit_cnt;
  logic [31:0]   trans_cnt;
  logic [31:0]   miss_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    return (ev && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // ---------------- outstanding refill tracking ----------------
  assign refill_stall_o = (outstanding == OUT_MAX);
  // Issues while stalled and completions at zero are dropped, so the
  // counter can neither overflow nor underflow.
  assign issue_ok = refill_issue_i & ~refill_stall_o;
  assign done_ok  = refill_done_i & (outstanding != '0);

  always_comb begin
    out_nxt = outstanding;
    if (issue_ok && !done_ok) begin
      out_nxt = outstanding + CW'(1);
    end else if (!issue_ok && done_ok) begin
      out_nxt = outstanding - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      pending     <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      // Built from the next count so the flag tracks the counter exactly.
      pending     <= (out_nxt != '0);
    end
  end

  // ---------------- control handshake FSM ----------------
  always_comb begin
    case (op)
      OP_ENABLE:  op_req = ctrl_req_enable_i;
      OP_DISABLE: op_req = ctrl_req_disable_i;
      default:    op_req = flush_req_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_DISABLED;
      op         <= OP_ENABLE;
      cache_en   <= 1'b0;
      cache_priv <= 1'b0;
    end else begin
      case (state)
        ST_DISABLED, ST_ENABLED: begin
          if (flush_req_i) begin
            op    <= OP_FLUSH;
            state <= ST_FL_DRAIN;
          end else if (ctrl_req_disable_i) begin
            op <= OP_DISABLE;
            if (state == ST_ENABLED) begin
              cache_en <= 1'b0;
              state    <= ST_DIS_DRAIN;
            end else begin
              state <= ST_ACK;
            end
          end else if (ctrl_req_enable_i) begin
            op <= OP_ENABLE;
            // Mode is only captured on a real disabled->enabled transition.
            if (state == ST_DISABLED) begin
              cache_en   <= 1'b1;
              cache_priv <= icache_is_private_i;
            end
            state <= ST_ACK;
          end
        end
        ST_DIS_DRAIN: if (outstanding == '0) state <= ST_ACK;
        ST_FL_DRAIN:  if (outstanding == '0) state <= ST_FL_WAIT;
        ST_FL_WAIT:   if (cache_flush_done_i) state <= ST_ACK;
        ST_ACK:       if (!op_req) state <= cache_en ? ST_ENABLED : ST_DISABLED;
        default:      state <= ST_DISABLED;
      endcase
    end
  end

  // The invalidate pulse lasts exactly the single FL_DRAIN cycle that sees
  // an empty refill pipe, since that same cycle moves the FSM to FL_WAIT.
  assign cache_flush_o      = (state == ST_FL_DRAIN) && (outstanding == '0);
  assign ctrl_ack_enable_o  = (state == ST_ACK) && (op == OP_ENABLE);
  assign ctrl_ack_disable_o = (state == ST_ACK) && (op == OP_DISABLE);
  assign flush_ack_o        = (state == ST_ACK) && (op == OP_FLUSH);
  assign cache_enable_o     = cache_en;
  assign cache_private_o    = cache_priv;
  assign ctrl_pending_trans_o = pending;

  // ---------------- performance counters ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl_clear_regs_i) begin
      hit_cnt   <= '0;
      trans_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      hit_cnt   <= sat_inc(hit_cnt,   ctrl_enable_regs_i & fetch_hit_i);
      trans_cnt <= sat_inc(trans_cnt, ctrl_enable_regs_i & fetch_valid_i);
      miss_cnt  <= sat_inc(miss_cnt,  ctrl_enable_regs_i & fetch_miss_i);
    end
  end

  assign ctrl_hit_count_o   = hit_cnt;
  assign ctrl_trans_count_o = trans_cnt;
  assign ctrl_miss_count_o  = miss_cnt;

endmodule

`default_nettype wire
